hdx_pad_link: RTL and testbench
===============================

# hdx_pad_link

Half-duplex single-wire serial initiator for one sg13g2_IOPadInOut4mA bidirectional pad. It drives the pad's c2p/c2p_en/p2c pins directly. Per transaction it transmits one 8-bit UART-style frame, releases the pad, waits a turnaround gap, then receives one 8-bit reply frame from the off-chip responder. It sits in the core between the pad ring and core logic, which sees a valid/ready request port and pulsed reply outputs. The board provides a pull-up, so a released pad idles high.

## Interface
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be ≥4.
- TURN_CYCLES, 4: cycles with the pad released between TX stop bit and RX listening; must be ≥1.
- RX_TIMEOUT_BITS, 32: bit periods to wait for a reply start edge.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; reset value 1.
- tx_data  in  8  byte to send; captured on handshake.
- rx_valid  out  1  one-cycle pulse when a good reply is received; reset 0.
- rx_data  out  8  reply byte; updates only with rx_valid; holds otherwise; reset 0x00.
- rx_frame_err  out  1  one-cycle pulse when the reply stop bit is sampled 0; reset 0.
- rx_timeout  out  1  one-cycle pulse when no reply starts in time; reset 0.
- busy  out  1  equals ~tx_ready; reset 0.
- pad_c2p  out  1  to pad c2p; reset 1.
- pad_c2p_en  out  1  to pad c2p_en (1 = drive); reset 0.
- pad_p2c  in  1  from pad p2c; asynchronous.

## Operation
- pad_p2c passes through a 2-flop synchronizer (rxs). A falling edge is rxs=0 with the previous rxs=1.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1.
- States: IDLE → TX → TURN → RX_WAIT → RX_START → RX_DATA → RX_STOP → IDLE.
- IDLE: pad_c2p_en=0, pad_c2p=1. On tx_valid&tx_ready, capture tx_data into the shift register → TX.
- TX: pad_c2p_en=1. pad_c2p shows bit index 0..9 of the frame. Each bit is held exactly CLKS_PER_BIT cycles. After bit 9 → TURN, with pad_c2p_en=0 and pad_c2p=1.
- TURN: pad released for TURN_CYCLES cycles → RX_WAIT. The synchronizer keeps running throughout.
- RX_WAIT: a timeout counter starts at 0. A falling edge → RX_START. If the counter reaches RX_TIMEOUT_BITS*CLKS_PER_BIT first → pulse rx_timeout → IDLE.
  - A line already low on entry is not an edge. A line stuck low therefore times out.
- RX_START: wait floor(CLKS_PER_BIT/2) cycles, then sample rxs.
  - 1: glitch → RX_WAIT; the timeout counter continues, it is not reset.
  - 0: → RX_DATA.
- RX_DATA: sample every CLKS_PER_BIT cycles from the start-bit midpoint. Shift 8 bits into the receive register LSB first → RX_STOP.
- RX_STOP: sample the stop bit one CLKS_PER_BIT after the last data bit.
  - 1: rx_data ← shift register; pulse rx_valid.
  - 0: pulse rx_frame_err; rx_data is unchanged.
  - Either way → IDLE.
- tx_valid outside IDLE is ignored. No request is queued.
- Counter widths are $clog2 of the maximum count + 1. No counter wraps within a state.
- rst at any clock edge: all state and outputs return to their reset values on that edge. The pad is released immediately, and no pulse outputs fire.

## Timing
- Handshake at edge N: at N+1, state=TX, pad_c2p_en=1, pad_c2p=0.
- The pad is driven for exactly 10*CLKS_PER_BIT cycles.
- pad_c2p_en falls on the same edge that begins TURN.
- RX_WAIT is entered exactly TURN_CYCLES cycles after pad release.
- rx_timeout asserts RX_TIMEOUT_BITS*CLKS_PER_BIT cycles after RX_WAIT entry, for 1 cycle. tx_ready=1 on the next cycle.
- Reply-edge latency: the synchronizer adds 2 cycles, so sample points are 2 cycles after the true pad bit centers (±1 cycle).
- rx_valid / rx_frame_err assert on the cycle after the stop-bit sample edge. tx_ready rises in that same cycle.
- A new handshake is possible in the first cycle tx_ready=1, including the cycle in which rx_valid pulses.
- At most one of rx_valid, rx_frame_err, rx_timeout fires per transaction.

## Test plan
Parameters: CLKS_PER_BIT=4, TURN_CYCLES=4, RX_TIMEOUT_BITS=32.
- Reset with rst high for 3 cycles → pad_c2p=1, pad_c2p_en=0, tx_ready=1, busy=0, rx_valid=rx_frame_err=rx_timeout=0, rx_data=0x00.
- Send 0xA5 → pad_c2p_en=1 for exactly 40 cycles. pad_c2p shows 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles. Then en=0, and busy stays 1 through TURN.
- Full transaction 0xA5, with the responder model driving 0x3C framed, starting 6 cycles after the line is released → exactly one rx_valid with rx_data=0x3C. tx_ready=1 in the same cycle. No error pulses.
- No responder → rx_timeout pulses once, 128 cycles after RX_WAIT entry. No rx_valid. tx_ready=1 next cycle.
- Glitch:
  - 1-cycle low pulse in RX_WAIT → no RX_DATA entry. A following valid 0x81 frame → rx_valid, rx_data=0x81.
  - A separate reply 0x55 with stop bit 0 → rx_frame_err pulse; rx_data keeps its prior value.
- Reset mid-TX during bit 4 → next cycle pad_c2p_en=0, pad_c2p=1, tx_ready=1, no pulses. Separately, tx_valid held high during busy causes no second frame until IDLE.

Source files
------------

// File: rtl/hdx_pad_link_if.sv
// Core-side request/reply bundle of the half-duplex pad link.
interface hdx_pad_link_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rx_timeout;
    logic       busy;

    modport master (output tx_valid, tx_data,
                    input  tx_ready, rx_valid, rx_data, rx_frame_err, rx_timeout, busy);
    modport slave  (input  tx_valid, tx_data,
                    output tx_ready, rx_valid, rx_data, rx_frame_err, rx_timeout, busy);
endinterface

// File: rtl/hdx_pad_link.sv
// Half-duplex single-wire initiator: sends one 8N1 frame on a bidirectional pad,
// releases it, then receives one 8N1 reply frame from the off-chip responder.
module hdx_pad_link #(
    parameter int CLKS_PER_BIT    = 16,
    parameter int TURN_CYCLES     = 4,
    parameter int RX_TIMEOUT_BITS = 32
) (
    input  logic          clk,
    input  logic          rst,
    hdx_pad_link_if.slave link,
    output logic          pad_c2p,
    output logic          pad_c2p_en,
    input  logic          pad_p2c
);
    localparam int CNT_MAX = (CLKS_PER_BIT > TURN_CYCLES) ? CLKS_PER_BIT : TURN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TO_MAX  = RX_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W    = $clog2(TO_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_MAX - 1);
    localparam logic [TO_W-1:0]  TO_END    = TO_W'(TO_MAX);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX       = 3'd1,
        TURN     = 3'd2,
        RX_WAIT  = 3'd3,
        RX_START = 3'd4,
        RX_DATA  = 3'd5,
        RX_STOP  = 3'd6
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TO_W-1:0]  to_q;
    logic [3:0]       bit_q;
    logic [9:0]       tx_sh_q;
    logic [7:0]       rx_sh_q;
    logic [7:0]       rx_data_q;
    logic [1:0]       sync_q;
    logic             rxs_prev_q;
    logic             tx_ready_q;
    logic             rx_valid_q;
    logic             rx_frame_err_q;
    logic             rx_timeout_q;
    logic             c2p_q;
    logic             c2p_en_q;
    logic             rxs_s;
    logic             fall_s;

    assign rxs_s  = sync_q[1];
    assign fall_s = ~rxs_s & rxs_prev_q;

    // Two-flop synchronizer plus edge history; idles high like the pulled-up line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], pad_p2c};
            rxs_prev_q <= sync_q[1];
        end
    end

    // Transaction FSM; pulse outputs default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            to_q           <= '0;
            bit_q          <= 4'd0;
            tx_sh_q        <= 10'h3FF;
            rx_sh_q        <= 8'h00;
            rx_data_q      <= 8'h00;
            tx_ready_q     <= 1'b1;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_timeout_q   <= 1'b0;
            c2p_q          <= 1'b1;
            c2p_en_q       <= 1'b0;
        end else begin
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_timeout_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (link.tx_valid) begin
                        tx_sh_q    <= {1'b1, link.tx_data, 1'b0};
                        c2p_q      <= 1'b0;
                        c2p_en_q   <= 1'b1;
                        tx_ready_q <= 1'b0;
                        cnt_q      <= '0;
                        bit_q      <= 4'd0;
                        state_q    <= TX;
                    end else begin
                        c2p_q    <= 1'b1;
                        c2p_en_q <= 1'b0;
                    end
                end
                TX: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 4'd9) begin
                            c2p_q    <= 1'b1;
                            c2p_en_q <= 1'b0;
                            state_q  <= TURN;
                        end else begin
                            bit_q   <= bit_q + 4'd1;
                            tx_sh_q <= {1'b1, tx_sh_q[9:1]};
                            c2p_q   <= tx_sh_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                TURN: begin
                    if (cnt_q == TURN_LAST) begin
                        to_q    <= '0;
                        state_q <= RX_WAIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                // The timeout pulses one cycle before the return to IDLE, so
                // tx_ready rises on the cycle after rx_timeout.
                RX_WAIT: begin
                    if (to_q == TO_END) begin
                        tx_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else if (fall_s) begin
                        cnt_q   <= '0;
                        state_q <= RX_START;
                    end else begin
                        rx_timeout_q <= (to_q == TO_LAST);
                        to_q         <= to_q + TO_ONE;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= 4'd0;
                        state_q <= rxs_s ? RX_WAIT : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        rx_sh_q <= {rxs_s, rx_sh_q[7:1]};
                        if (bit_q == 4'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        if (rxs_s) begin
                            rx_data_q  <= rx_sh_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            rx_frame_err_q <= 1'b1;
                        end
                        cnt_q      <= '0;
                        tx_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    c2p_q      <= 1'b1;
                    c2p_en_q   <= 1'b0;
                    tx_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign link.tx_ready     = tx_ready_q;
    assign link.busy         = ~tx_ready_q;
    assign link.rx_valid     = rx_valid_q;
    assign link.rx_data      = rx_data_q;
    assign link.rx_frame_err = rx_frame_err_q;
    assign link.rx_timeout   = rx_timeout_q;
    assign pad_c2p           = c2p_q;
    assign pad_c2p_en        = c2p_en_q;
endmodule

// File: tb/tb_hdx_pad_link.sv
// Self-checking bench for hdx_pad_link: pad waveform, reply reception, timeout,
// glitch rejection, frame errors, reset and back-to-back requests.
module tb_hdx_pad_link;
    localparam int CPB = 4;
    localparam int TC  = 4;
    localparam int TOB = 32;
    localparam int TO_PULSE_K = 10 * CPB + TC + TOB * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       pad_c2p;
    logic       pad_c2p_en;
    logic       pad_p2c;
    logic       resp_q;
    logic [7:0] model_rx_data;
    int         checks   = 0;
    int         failures = 0;

    hdx_pad_link_if link ();

    hdx_pad_link #(
        .CLKS_PER_BIT   (CPB),
        .TURN_CYCLES    (TC),
        .RX_TIMEOUT_BITS(TOB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .link      (link),
        .pad_c2p   (pad_c2p),
        .pad_c2p_en(pad_c2p_en),
        .pad_p2c   (pad_p2c)
    );

    always #5 clk = ~clk;

    // Pad with board pull-up: the initiator wins when driving, else the responder.
    assign pad_p2c = pad_c2p_en ? pad_c2p : resp_q;

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        else if (i == 9) return 1'b1;
        else return b[i-1];
    endfunction

    task automatic check_idle_outputs(input string name);
        checks++;
        if (pad_c2p !== 1'b1 || pad_c2p_en !== 1'b0 || link.tx_ready !== 1'b1 || link.busy !== 1'b0 ||
            link.rx_valid !== 1'b0 || link.rx_frame_err !== 1'b0 || link.rx_timeout !== 1'b0 ||
            link.rx_data !== model_rx_data) begin
            failures++;
            $display("FAIL %s got c2p=%b en=%b rdy=%b busy=%b v=%b fe=%b to=%b data=%h want 1 0 1 0 0 0 0 data=%h",
                     name, pad_c2p, pad_c2p_en, link.tx_ready, link.busy, link.rx_valid,
                     link.rx_frame_err, link.rx_timeout, link.rx_data, model_rx_data);
        end
    endtask

    // Handshake then check all 10 bit periods; returns at the first released cycle.
    task automatic send_frame(input logic [7:0] b, input bit hold);
        @(negedge clk);
        link.tx_valid = 1'b1;
        link.tx_data  = b;
        @(negedge clk);
        if (!hold) link.tx_valid = 1'b0;
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (pad_c2p_en !== 1'b1 || pad_c2p !== frame_bit(b, k / CPB)) begin
                failures++;
                $display("FAIL tx_bit byte=%h k=%0d got en=%b c2p=%b want en=1 c2p=%b",
                         b, k, pad_c2p_en, pad_c2p, frame_bit(b, k / CPB));
            end
        end
        @(negedge clk);
        checks++;
        if (pad_c2p_en !== 1'b0 || pad_c2p !== 1'b1) begin
            failures++;
            $display("FAIL tx_release got en=%b c2p=%b want en=0 c2p=1", pad_c2p_en, pad_c2p);
        end
    endtask

    // kind: 0 good reply, 1 frame error, 2 timeout. delay<0 means silent responder.
    task automatic run_rx(input logic [7:0] b, input logic stop, input int delay,
                          input int glitch_at, input int kind, input bit hold);
        int nv, nfe, nto, to_k, done_k;
        nv = 0; nfe = 0; nto = 0; to_k = -1; done_k = -1;
        fork
            begin
                if (delay >= 0) begin
                    for (int c = 0; c < delay; c++) begin
                        resp_q = (c == glitch_at) ? 1'b0 : 1'b1;
                        @(negedge clk);
                    end
                    for (int i = 0; i < 10; i++) begin
                        resp_q = (i == 9) ? stop : frame_bit(b, i);
                        repeat (CPB) @(negedge clk);
                    end
                    resp_q = 1'b1;
                end
            end
            begin
                for (int k = 10 * CPB + 1; k < 400 && done_k < 0; k++) begin
                    @(negedge clk);
                    if (link.rx_valid === 1'b1) begin
                        nv++;
                        checks++;
                        if (link.tx_ready !== 1'b1 || link.rx_data !== b) begin
                            failures++;
                            $display("FAIL rx_valid_data got rdy=%b data=%h want rdy=1 data=%h",
                                     link.tx_ready, link.rx_data, b);
                        end
                    end
                    if (link.rx_frame_err === 1'b1) begin
                        nfe++;
                        checks++;
                        if (link.tx_ready !== 1'b1 || link.rx_data !== model_rx_data) begin
                            failures++;
                            $display("FAIL frame_err_hold got rdy=%b data=%h want rdy=1 data=%h",
                                     link.tx_ready, link.rx_data, model_rx_data);
                        end
                    end
                    if (link.rx_timeout === 1'b1) begin
                        nto++;
                        to_k = k;
                    end
                    if (k < 10 * CPB + TC) begin
                        checks++;
                        if (link.busy !== 1'b1 || pad_c2p_en !== 1'b0) begin
                            failures++;
                            $display("FAIL turn_busy k=%0d got busy=%b en=%b want busy=1 en=0",
                                     k, link.busy, pad_c2p_en);
                        end
                    end
                    if (link.tx_ready === 1'b0 && pad_c2p_en !== 1'b0) begin
                        checks++;
                        failures++;
                        $display("FAIL rx_pad_driven k=%0d got en=%b want 0", k, pad_c2p_en);
                    end
                    if (link.tx_ready === 1'b1) done_k = k;
                end
                checks++;
                if (done_k < 0) begin
                    failures++;
                    $display("FAIL rx_done_bound got no tx_ready within 400 cycles want tx_ready=1");
                end
                if (hold) begin
                    @(negedge clk);
                    checks++;
                    if (pad_c2p_en !== 1'b1 || pad_c2p !== 1'b0) begin
                        failures++;
                        $display("FAIL b2b_accept got en=%b c2p=%b want en=1 c2p=0", pad_c2p_en, pad_c2p);
                    end
                end
            end
        join
        checks++;
        if (nv != (kind == 0 ? 1 : 0) || nfe != (kind == 1 ? 1 : 0) || nto != (kind == 2 ? 1 : 0)) begin
            failures++;
            $display("FAIL rx_outcome got valid=%0d ferr=%0d tout=%0d want kind=%0d", nv, nfe, nto, kind);
        end
        if (kind == 2) begin
            checks++;
            if (to_k != TO_PULSE_K || done_k != TO_PULSE_K + 1) begin
                failures++;
                $display("FAIL timeout_timing got pulse_k=%0d ready_k=%0d want %0d %0d",
                         to_k, done_k, TO_PULSE_K, TO_PULSE_K + 1);
            end
        end
        if (kind == 0) model_rx_data = b;
        checks++;
        if (link.rx_data !== model_rx_data) begin
            failures++;
            $display("FAIL rx_data_after got %h want %h", link.rx_data, model_rx_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_rx_data = 8'h00;
        check_idle_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_tx_timeout();
        send_frame(8'hA5, 1'b0);
        run_rx(8'h00, 1'b1, -1, -1, 2, 1'b0);
    endtask

    task automatic test_full_txn();
        send_frame(8'hA5, 1'b0);
        run_rx(8'h3C, 1'b1, 6, -1, 0, 1'b0);
    endtask

    task automatic test_glitch_and_frame_err();
        send_frame(8'h5A, 1'b0);
        run_rx(8'h81, 1'b1, 30, 6, 0, 1'b0);
        send_frame(8'hC3, 1'b0);
        run_rx(8'h55, 1'b0, 8, -1, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            logic [7:0] tb_b, rb;
            logic       st;
            tb_b = 8'($urandom);
            rb   = 8'($urandom);
            st   = ($urandom_range(0, 3) != 0);
            send_frame(tb_b, 1'b0);
            run_rx(rb, st, $urandom_range(3, 30), -1, st ? 0 : 1, 1'b0);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] b;
        b = 8'($urandom);
        @(negedge clk);
        link.tx_valid = 1'b1;
        link.tx_data  = b;
        @(negedge clk);
        link.tx_valid = 1'b0;
        repeat (4 * CPB + 1) @(negedge clk);
        checks++;
        if (pad_c2p_en !== 1'b1 || pad_c2p !== frame_bit(b, 4)) begin
            failures++;
            $display("FAIL mid_tx_bit4 got en=%b c2p=%b want en=1 c2p=%b", pad_c2p_en, pad_c2p, frame_bit(b, 4));
        end
        rst = 1'b1;
        @(negedge clk);
        model_rx_data = 8'h00;
        check_idle_outputs("reset_mid_tx");
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        send_frame(8'h96, 1'b1);
        run_rx(8'h6D, 1'b1, 5, -1, 0, 1'b1);
        link.tx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        model_rx_data = 8'h00;
        check_idle_outputs("b2b_reset");
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        resp_q        = 1'b1;
        link.tx_valid = 1'b0;
        link.tx_data  = 8'h00;
        model_rx_data = 8'h00;
        test_reset();
        test_tx_timeout();
        test_full_txn();
        test_glitch_and_frame_err();
        test_random();
        test_reset_mid_tx();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got simulation still running want finished");
        $fatal(1);
    end
endmodule
